// File: rtl/sram_ctrl.sv
// sram_ctrl: valid/ready front end for a single-port DEPTH x DATA_W sram; SRAM_CLEAR_EN adds a post-reset zero-fill.
module sram_ctrl #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);
  localparam logic [1:0] IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2;
`ifdef SRAM_CLEAR_EN
  localparam logic [1:0] INIT = 2'd3;
  localparam logic [1:0] RST_ST = INIT;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
`else
  localparam logic [1:0] RST_ST = IDLE;
`endif
  logic [1:0]        state_q, state_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              accept;
  always_comb begin
    accept  = state_q == IDLE && req_valid;
    state_d = accept ? ACCESS :
              state_q == ACCESS ? RESP :
              (state_q == RESP && rsp_ready) ? IDLE : state_q;
    we_d    = accept ? req_we : we_q;
    addr_d  = accept ? req_addr : addr_q;
    wdata_d = accept ? req_wdata : wdata_q;
    rdata_d = state_q == ACCESS ? (we_q ? wdata_q : mem_rdata) : rdata_q;
`ifdef SRAM_CLEAR_EN
    cnt_d   = (state_q == INIT && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
    state_d = (state_q == INIT && cnt_q == '1) ? IDLE : state_d;
`endif
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RST_ST;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
`ifdef SRAM_CLEAR_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
`ifdef SRAM_CLEAR_EN
      cnt_q   <= cnt_d;
`endif
    end
  end
  assign req_ready = state_q == IDLE;
  assign rsp_valid = state_q == RESP;
  assign rsp_rdata = rdata_q;
`ifdef SRAM_CLEAR_EN
  // rst_n gating keeps the fill from writing while reset is still held
  assign mem_addr  = state_q == INIT ? cnt_q : addr_q;
  assign mem_wdata = state_q == INIT ? '0 : wdata_q;
  assign mem_we    = rst_n && (state_q == INIT || (state_q == ACCESS && we_q));
`else
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_we    = state_q == ACCESS && we_q;
`endif
endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: random request stream against a word-array reference of the sram contents.
module tb_sram_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0, req_ready, req_we = 1'b0;
  logic [3:0] req_addr = '0;
  logic [7:0] req_wdata = '0;
  logic       rsp_valid, rsp_ready = 1'b1;
  logic [7:0] rsp_rdata;
  logic [3:0] mem_addr;
  logic [7:0] mem_wdata, mem_rdata;
  logic       mem_we;
  logic [7:0] sram [16];
  logic [7:0] ref_mem [16];
  int n_vec = 0, n_err = 0;

  sram_ctrl #(.ADDR_W(4), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (mem_we) sram[mem_addr] <= mem_wdata;
  assign mem_rdata = sram[mem_addr];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    #3;
`ifdef SRAM_CLEAR_EN
    chk("rst_req_ready", req_ready, 0);
`else
    chk("rst_req_ready", req_ready, 1);
`endif
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    @(negedge clk);
    rst_n = 1'b1;
`ifdef SRAM_CLEAR_EN
    #1;
    for (int i = 0; i < 16; i++) begin
      chk("init_req_ready", req_ready, 0);
      chk("init_rsp_valid", rsp_valid, 0);
      chk("init_mem_we", mem_we, 1);
      chk("init_mem_addr", mem_addr, i);
      chk("init_mem_wdata", mem_wdata, 0);
      @(negedge clk);
    end
    for (int i = 0; i < 16; i++) ref_mem[i] = 8'h00;
`else
    @(negedge clk);
`endif
    chk("post_rst_req_ready", req_ready, 1);
    chk("post_rst_rsp_valid", rsp_valid, 0);
  endtask

  // Called on a falling edge with the controller idle; returns on the falling edge after the response.
  task automatic req(input logic we, input logic [3:0] a, input logic [7:0] d, input int stall);
    logic [7:0] exp;
    chk("idle_req_ready", req_ready, 1);
    exp = we ? d : ref_mem[a];
    if (we) ref_mem[a] = d;
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
    rsp_ready = 1'($urandom_range(1));
    @(negedge clk);
    req_valid = 1'b0;
    req_we = 1'($urandom_range(1)); req_addr = 4'($urandom); req_wdata = 8'($urandom);
    chk("acc_mem_we", mem_we, we);
    chk("acc_mem_addr", mem_addr, a);
    if (we) chk("acc_mem_wdata", mem_wdata, d);
    chk("acc_rsp_valid", rsp_valid, 0);
    chk("acc_req_ready", req_ready, 0);
    rsp_ready = stall == 0;
    @(negedge clk);
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_rdata", rsp_rdata, exp);
    chk("rsp_mem_we", mem_we, 0);
    chk("rsp_req_ready", req_ready, 0);
    for (int i = 0; i < stall; i++) begin
      req_valid = 1'($urandom_range(1));
      @(negedge clk);
      chk("stall_rsp_valid", rsp_valid, 1);
      chk("stall_rsp_rdata", rsp_rdata, exp);
      chk("stall_req_ready", req_ready, 0);
      chk("stall_mem_we", mem_we, 0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("done_rsp_valid", rsp_valid, 0);
    chk("done_req_ready", req_ready, 1);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) sram[i] = 8'h5A;
    do_reset();
`ifdef SRAM_CLEAR_EN
    req(1'b0, 4'd5, 8'h00, 0);
`endif
    req(1'b1, 4'd3, 8'hA5, 0);
    req(1'b0, 4'd3, 8'h00, 0);
    req(1'b0, 4'd3, 8'h00, 5);
    for (int i = 0; i < 16; i++) req(1'b1, 4'(i), 8'(i) ^ 8'hFF, 0);
    req(1'b0, 4'd15, 8'h00, 0);
    req(1'b0, 4'd0, 8'h00, 0);
    req(1'b0, 4'd7, 8'h00, 0);
    chk("t4_ref15", ref_mem[15], 8'hF0);
    chk("t4_ref7", ref_mem[7], 8'hF8);
    for (int n = 0; n < 60; n++)
      req(1'($urandom_range(1)), 4'($urandom), 8'($urandom),
          $urandom_range(3) == 0 ? int'($urandom_range(3, 1)) : 0);
    req(1'b1, 4'd9, 8'h3C, 0);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 4'd9; req_wdata = 8'hC3;
    @(negedge clk);
    req_valid = 1'b0;
    chk("t5_acc_mem_we", mem_we, 1);
    #1;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t5_no_rsp", rsp_valid, 0);
    end
    req(1'b0, 4'd9, 8'h00, 0);
    for (int n = 0; n < 20; n++)
      req(1'($urandom_range(1)), 4'($urandom), 8'($urandom), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
